// File: rtl/cd_i2s_feeder.sv
// cd_i2s_feeder
//   CD-drive side serializer for the Butch I2S receiver (its i2rxd pin).
//   16-bit sample words are buffered in a FIFO and shifted out MSB-first.
//   The shifts are aligned to the sck/ws pair that the receiver drives in
//   master mode. Standard I2S timing applies: the MSB appears one sck after
//   each ws edge, and ws low selects the left word.
//
// Ports
//   sys_clk    : single system clock, all state updates on its rising edge
//   resetl     : asynchronous active-low reset
//   enable     : 1 = serializer runs, 0 = held in IDLE with sdata_out = 0
//   flush      : synchronous pulse that empties the FIFO and returns to IDLE
//   wr_en      : push wr_data into the FIFO
//   wr_data    : sample word; left and right alternate, left first
//   full       : FIFO holds 2**FIFO_AW words
//   level      : number of words currently in the FIFO
//   sck_in     : bit clock from the receiver (asynchronous, slow)
//   ws_in      : word select from the receiver
//   sdata_out  : serial data to the receiver
//   underflow  : sticky; set when a word load found the FIFO empty
//   overflow   : sticky; set on wr_en while full with no same-cycle pop
//   flag_clr   : synchronous clear of underflow and overflow

module cd_i2s_feeder #(
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               enable,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [15:0]        wr_data,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  input  logic               sck_in,
  input  logic               ws_in,
  output logic               sdata_out,
  output logic               underflow,
  output logic               overflow,
  input  logic               flag_clr
);

  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sr, ws_sr;
  logic                   sck_rise, sck_fall, ws_sync, ws_q, ws_chg;
  logic                   load_pend, load_evt, shift_evt;
  logic [15:0]            mem [DEPTH];
  logic [FIFO_AW:0]       wr_ptr, rd_ptr;
  logic                   empty, push_ok, pop_ok;
  logic [15:0]            load_word;
  logic [15:0]            shreg;
  logic [3:0]             bitcnt;

  // ---------------- synchronizers and edge detect ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      sck_sr <= '0;
      ws_sr  <= '0;
    end else begin
      sck_sr <= {sck_sr[SYNC_STAGES-2:0], sck_in};
      ws_sr  <= {ws_sr[SYNC_STAGES-2:0], ws_in};
    end
  end

  assign sck_rise = sck_sr[SYNC_STAGES-2] & ~sck_sr[SYNC_STAGES-1];
  assign sck_fall = ~sck_sr[SYNC_STAGES-2] & sck_sr[SYNC_STAGES-1];
  assign ws_sync  = ws_sr[SYNC_STAGES-1];
  // ws is sampled on sck rise, as the receiver does; a change marks a word slot
  assign ws_chg   = sck_rise & (ws_sync != ws_q);

  // ---------------- FIFO ----------------
  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == DEPTH_W);
  assign empty     = (level == '0);
  // a pop frees the slot in the same cycle, so push while full is legal then
  assign push_ok   = wr_en & ~flush & (~full | load_evt);
  assign pop_ok    = load_evt & ~empty;
  assign load_word = empty ? 16'h0000 : mem[rd_ptr[FIFO_AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define content,
  // which keeps it mappable to plain RAM/register-file cells.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      // a set event in the same cycle overrides flag_clr
      if (load_evt & empty)                    underflow <= 1'b1;
      else if (flag_clr)                       underflow <= 1'b0;
      if (wr_en & ~flush & full & ~load_evt)   overflow  <= 1'b1;
      else if (flag_clr)                       overflow  <= 1'b0;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    if (flush || !enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        // only a change towards ws=0 (left word) starts the stream
        ST_IDLE:  if (ws_chg && !ws_sync)   state_nxt = ST_LOAD;
        ST_LOAD:  if (sck_fall && load_pend) state_nxt = ST_SHIFT;
        ST_SHIFT: state_nxt = ST_SHIFT;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_evt  = 1'b0;
    shift_evt = 1'b0;
    if (enable && !flush && sck_fall && state != ST_IDLE) begin
      // a pending word slot always beats the remaining bits (truncation)
      load_evt  = load_pend;
      shift_evt = !load_pend && (state == ST_SHIFT);
    end
  end

  // ---------------- serializer datapath ----------------
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      ws_q      <= 1'b0;
      load_pend <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      sdata_out <= 1'b0;
    end else begin
      if (sck_rise) ws_q <= ws_sync;

      if (flush)         load_pend <= 1'b0;
      else if (ws_chg)   load_pend <= 1'b1;
      else if (load_evt) load_pend <= 1'b0;

      if (flush || !enable || state == ST_IDLE) begin
        sdata_out <= 1'b0;
      end else if (load_evt) begin
        // an empty FIFO still consumes the slot so L/R pairing is kept
        shreg     <= load_word;
        sdata_out <= load_word[15];
        bitcnt    <= 4'd15;
      end else if (shift_evt) begin
        if (bitcnt != 4'd0) begin
          sdata_out <= shreg[bitcnt - 4'd1];
          bitcnt    <= bitcnt - 4'd1;
        end else begin
          sdata_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cd_i2s_feeder.sv
// tb_cd_i2s_feeder
//   Directed bench for cd_i2s_feeder. The bench plays the I2S receiver:
//   it drives a slow sck (16 sys_clk per period) with ws changing on sck
//   fall, and records sdata_out just before each sck rise, where the
//   receiver samples it. Expected words are hand-computed constants.

module tb_cd_i2s_feeder;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        enable, flush, wr_en, flag_clr;
  logic [15:0] wr_data;
  logic        full;
  logic [4:0]  level;
  logic        sck_in, ws_in;
  logic        sdata_out, underflow, overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic samp [1024];
  int   nsamp = 0;

  cd_i2s_feeder #(.FIFO_AW(4), .SYNC_STAGES(2)) dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .enable    (enable),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .sck_in    (sck_in),
    .ws_in     (ws_in),
    .sdata_out (sdata_out),
    .underflow (underflow),
    .overflow  (overflow),
    .flag_clr  (flag_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one sck period; optionally pushes a word aligned with the internal
  // sck_fall pulse (two sys_clk after the pin falls)
  task automatic sck_cycle(input logic ws_v, input logic push, input logic [15:0] d);
    sck_in = 1'b0;
    ws_in  = ws_v;
    @(negedge sys_clk);
    if (push) begin
      wr_en   = 1'b1;
      wr_data = d;
    end
    @(negedge sys_clk);
    wr_en = 1'b0;
    repeat (6) @(negedge sys_clk);
    samp[nsamp] = sdata_out;
    nsamp++;
    sck_in = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic run(input logic ws_v, input int n);
    for (int i = 0; i < n; i++) sck_cycle(ws_v, 1'b0, 16'h0000);
  endtask

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge sys_clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic do_clr();
    flag_clr = 1'b1;
    @(negedge sys_clk);
    flag_clr = 1'b0;
    @(negedge sys_clk);
  endtask

  function automatic logic [15:0] get_word(input int s);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], samp[s+i]};
    return w;
  endfunction

  function automatic logic any_one(input int from, input int to);
    logic r = 1'b0;
    for (int i = from; i < to; i++) r = r | samp[i];
    return r;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, s0;
    resetl = 1'b0; enable = 1'b0; flush = 1'b0; wr_en = 1'b0;
    flag_clr = 1'b0; wr_data = '0; sck_in = 1'b1; ws_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    resetl = 1'b1;
    @(negedge sys_clk);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_sdata", sdata_out, 0);
    check("rst_flags", {underflow, overflow}, 0);

    // 1: two words, full left/right frame
    push(16'hA5C3);
    push(16'h1234);
    check("t1_level", level, 2);
    enable = 1'b1;
    run(1'b1, 2);
    e = nsamp;
    run(1'b0, 16);
    run(1'b1, 16);
    run(1'b0, 1);
    check("t1_left", get_word(e + 1), 16'hA5C3);
    check("t1_right", get_word(e + 17), 16'h1234);
    check("t1_underflow", underflow, 0);

    // 2: FIFO now empty, two more frames give zeros and underflow
    s0 = nsamp;
    run(1'b0, 15);
    run(1'b1, 16);
    run(1'b0, 16);
    run(1'b1, 16);
    check("t2_zeros", any_one(s0, nsamp), 0);
    check("t2_underflow", underflow, 1);
    do_clr();
    check("t2_clr", underflow, 0);

    // 3: fill, overflow, push+pop while full
    enable = 1'b0;
    do_flush();
    check("t3_flush_level", level, 0);
    for (int i = 0; i < 16; i++) push(16'hC000 | 16'(i));
    check("t3_full", full, 1);
    check("t3_level16", level, 16);
    push(16'hDEAD);
    check("t3_overflow", overflow, 1);
    check("t3_level_kept", level, 16);
    do_clr();
    check("t3_ovf_clr", overflow, 0);
    enable = 1'b1;
    run(1'b1, 2);
    run(1'b0, 1);
    e = nsamp;
    sck_cycle(1'b0, 1'b1, 16'h7777);
    check("t3_pushpop_level", level, 16);
    check("t3_pushpop_ovf", overflow, 0);
    run(1'b0, 14);
    run(1'b1, 1);
    check("t3_word0", get_word(e), 16'hC000);

    // 4: enable mid-word with ws already low
    enable = 1'b0;
    do_flush();
    run(1'b0, 4);
    push(16'hBEEF);
    push(16'h1357);
    enable = 1'b1;
    s0 = nsamp;
    run(1'b0, 6);
    run(1'b1, 16);
    e = nsamp;
    run(1'b0, 16);
    run(1'b1, 1);
    check("t4_quiet", any_one(s0, e + 1), 0);
    check("t4_left", get_word(e + 1), 16'hBEEF);
    check("t4_level", level, 1);

    // 5: short left word truncated by an early ws edge
    enable = 1'b0;
    do_flush();
    run(1'b1, 2);
    push(16'hF00F);
    push(16'h9C3A);
    enable = 1'b1;
    run(1'b1, 2);
    e = nsamp;
    run(1'b0, 8);
    run(1'b1, 16);
    run(1'b0, 1);
    check("t5_trunc", get_word(e + 1), 16'hF09C);
    check("t5_second", get_word(e + 9), 16'h9C3A);
    check("t5_flags", {underflow, overflow}, 0);

    // 6a: async reset mid-word
    enable = 1'b0;
    do_flush();
    push(16'hFFFF);
    push(16'h0001);
    push(16'h0002);
    enable = 1'b1;
    run(1'b1, 2);
    run(1'b0, 1);
    run(1'b0, 5);
    check("t6_pre_sdata", sdata_out, 1);
    check("t6_pre_level", level, 2);
    resetl = 1'b0;
    #1;
    check("t6_rst_sdata", sdata_out, 0);
    check("t6_rst_level", level, 0);
    @(negedge sys_clk);
    resetl = 1'b1;
    @(negedge sys_clk);

    // 6b: flush mid-word keeps the flags
    for (int i = 0; i < 17; i++) push(16'hFFFF);
    check("t6_ovf_set", overflow, 1);
    run(1'b1, 2);
    run(1'b0, 1);
    run(1'b0, 4);
    check("t6_shift_sdata", sdata_out, 1);
    check("t6_shift_level", level, 15);
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    check("t6_fl_level", level, 0);
    check("t6_fl_sdata", sdata_out, 0);
    check("t6_fl_flags", {underflow, overflow}, 2'b01);
    s0 = nsamp;
    run(1'b0, 3);
    check("t6_idle_quiet", any_one(s0, nsamp), 0);
    check("t6_idle_uflow", underflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
